// File: rtl/pifo_root_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : pifo_root_ctrl_if
// Brief  : Push / pop / dequeue handshake bundle for the PIFO root controller.
// Rev    : 1.0
// ============================================================================
interface pifo_root_ctrl_if #(
  parameter int DW = 48
) ();
  logic          i_push_valid;
  logic          o_push_ready;
  logic [DW-1:0] i_push_data;
  logic          i_pop_valid;
  logic          o_pop_ready;
  logic          o_deq_valid;
  logic          i_deq_ready;
  logic [DW-1:0] o_deq_data;

  modport master (
    output i_push_valid, i_push_data, i_pop_valid, i_deq_ready,
    input  o_push_ready, o_pop_ready, o_deq_valid, o_deq_data
  );

  modport slave (
    input  i_push_valid, i_push_data, i_pop_valid, i_deq_ready,
    output o_push_ready, o_pop_ready, o_deq_valid, o_deq_data
  );
endinterface
`default_nettype wire

// File: rtl/pifo_root_ctrl.sv
`default_nettype none
// ============================================================================
// Module : pifo_root_ctrl
// Brief  : Front-end for the SRAM PIFO tree: merges push/pop, sequences the
//          root pop bubble, tracks occupancy, holds one dequeued entry.
// Rev    : 1.0
// ============================================================================
module pifo_root_ctrl #(
  parameter int PTW  = 16,
  parameter int MTW  = 32,
  parameter int CAP  = 1024,
  parameter int CNTW = 11
) (
  input  wire logic                 i_clk,
  input  wire logic                 i_rst,
  pifo_root_ctrl_if.slave           bus,
  output logic                      o_root_push,
  output logic [MTW+PTW-1:0]        o_root_push_data,
  output logic                      o_root_pop,
  input  wire logic [MTW+PTW-1:0]   i_root_pop_data,
  output logic [CNTW-1:0]           o_count,
  output logic                      o_empty,
  output logic                      o_full
);
  localparam int DW = MTW + PTW;

  typedef enum logic [1:0] {
    S_RDY   = 2'd0,
    S_ISSUE = 2'd1,
    S_CAPT  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNTW-1:0]   count_q, count_d;
  logic              root_push_q, root_push_d;
  logic              root_pop_q, root_pop_d;
  logic [DW-1:0]     root_push_data_q, root_push_data_d;
  logic              deq_valid_q, deq_valid_d;
  logic [DW-1:0]     deq_data_q, deq_data_d;

  logic empty, full, pop_ready, pop_hs, push_ready, push_hs;

  always_comb begin
    empty      = (count_q == '0);
    full       = (count_q == CNTW'(CAP));
    // Pop needs a free deq slot by the time the result lands; readies drop in reset.
    pop_ready  = !i_rst && (state_q == S_RDY) && !empty &&
                 (!deq_valid_q || bus.i_deq_ready);
    pop_hs     = bus.i_pop_valid && pop_ready;
    push_ready = !i_rst && ((state_q == S_RDY) || (state_q == S_CAPT)) &&
                 (!full || pop_hs);
    push_hs    = bus.i_push_valid && push_ready;

    root_push_d      = push_hs;
    root_pop_d       = pop_hs;
    root_push_data_d = push_hs ? bus.i_push_data : root_push_data_q;

    state_d = state_q;
    case (state_q)
      S_RDY:   if (pop_hs) state_d = S_ISSUE;
      S_ISSUE: state_d = S_CAPT;
      S_CAPT:  state_d = S_RDY;
      default: state_d = S_RDY;
    endcase

    deq_valid_d = deq_valid_q;
    deq_data_d  = deq_data_q;
    if (state_q == S_CAPT) begin
      deq_valid_d = 1'b1;
      deq_data_d  = i_root_pop_data;
    end else if (bus.i_deq_ready) begin
      deq_valid_d = 1'b0;
    end

    count_d = count_q;
    if (push_hs && !pop_hs)
      count_d = count_q + CNTW'(1);
    else if (pop_hs && !push_hs)
      count_d = count_q - CNTW'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q          <= S_RDY;
      count_q          <= '0;
      root_push_q      <= 1'b0;
      root_pop_q       <= 1'b0;
      root_push_data_q <= '0;
      deq_valid_q      <= 1'b0;
      deq_data_q       <= '0;
    end else begin
      state_q          <= state_d;
      count_q          <= count_d;
      root_push_q      <= root_push_d;
      root_pop_q       <= root_pop_d;
      root_push_data_q <= root_push_data_d;
      deq_valid_q      <= deq_valid_d;
      deq_data_q       <= deq_data_d;
    end
  end

  assign bus.o_push_ready = push_ready;
  assign bus.o_pop_ready  = pop_ready;
  assign bus.o_deq_valid  = deq_valid_q;
  assign bus.o_deq_data   = deq_data_q;
  assign o_root_push      = root_push_q;
  assign o_root_pop       = root_pop_q;
  assign o_root_push_data = root_push_data_q;
  assign o_count          = count_q;
  assign o_empty          = empty;
  assign o_full           = full;
endmodule
`default_nettype wire
